// File: rtl/eth_pkg.sv
// Shared Ethernet II definitions for the rx header parser: header geometry,
// well-known ethertypes, the broadcast address, header struct and parser states.
package eth_pkg;

  localparam int ETH_HDR_BYTES = 14;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [47:0] ETH_BCAST_MAC  = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] ethertype;
  } eth_hdr_t;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } rx_hdr_state_t;

endpackage

// File: rtl/eth_axis_skid_buf.sv
// Two-entry AXI-stream skid buffer: registered tvalid/tdata/tlast on the output
// and a registered ready on the input, giving full throughput with one cycle of latency.
module eth_axis_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_trdy,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_trdy
);

  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_last_q, skid_last_d;
  logic              rdy_q, rdy_d;
  logic              in_fire;

  assign in_fire  = s_tvalid & rdy_q;
  assign s_trdy   = rdy_q;
  assign m_tdata  = out_data_q;
  assign m_tvalid = out_vld_q;
  assign m_tlast  = out_last_q;

  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    // Output register free: refill from the skid entry first to keep byte order.
    if (!out_vld_q || m_trdy) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = skid_data_q;
        out_last_d = skid_last_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_fire;
        if (in_fire) begin
          out_data_d = s_tdata;
          out_last_d = s_tlast;
        end
      end
    end else if (in_fire) begin
      skid_vld_d  = 1'b1;
      skid_data_d = s_tdata;
      skid_last_d = s_tlast;
    end
    rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  always_ff @(posedge i_clk) begin
    skid_data_q <= skid_data_d;
    skid_last_q <= skid_last_d;
  end

endmodule

// File: rtl/ethernet_rx_hdr_parser.sv
// Ethernet II rx header parser: strips the 14-byte header into sideband fields and
// forwards payload bytes. Define ETH_RX_MAC_FILTER_EN to drop frames not addressed to i_mac_addr/broadcast.
module ethernet_rx_hdr_parser
  import eth_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 8,
  parameter int MAC_ADDR_WIDTH  = 48,
  parameter int ETHERTYPE_WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [AXI_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_trdy,
  output logic [AXI_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_trdy,
  output logic [MAC_ADDR_WIDTH-1:0]  m_hdr_dest_mac,
  output logic [MAC_ADDR_WIDTH-1:0]  m_hdr_src_mac,
  output logic [ETHERTYPE_WIDTH-1:0] m_hdr_ethertype,
  output logic                       m_hdr_valid,
  input  logic [MAC_ADDR_WIDTH-1:0]  i_mac_addr,
  output logic                       o_runt_err,
  output logic                       o_frame_drop
);

  localparam logic [3:0] HDR_LAST_IDX = 4'(ETH_HDR_BYTES - 1);

  rx_hdr_state_t                        state_q, state_d;
  logic [3:0]                           cnt_q, cnt_d;
  logic [8*(ETH_HDR_BYTES-1)-1:0]       shadow_q, shadow_d;
  eth_hdr_t                             hdr_q, hdr_d, hdr_next;
  logic                                 hdr_vld_q, hdr_vld_d;
  logic                                 runt_q, runt_d;
  logic                                 drop_q, drop_d;
  logic                                 en_q;
  logic                                 in_fire, hdr_last, pass, out_done;
  logic                                 skid_s_valid, skid_s_trdy;

  assign hdr_last     = (cnt_q == HDR_LAST_IDX);
  assign hdr_next     = {shadow_q, s_axis_tdata};
  assign in_fire      = s_axis_tvalid & s_axis_trdy;
  assign out_done     = m_axis_tvalid & m_axis_trdy & m_axis_tlast;
  assign skid_s_valid = s_axis_tvalid & (state_q == ST_PAYLOAD);

`ifdef ETH_RX_MAC_FILTER_EN
  assign pass = (hdr_next.dest == i_mac_addr) || (hdr_next.dest == ETH_BCAST_MAC);
`else
  logic unused_mac;
  assign unused_mac = ^i_mac_addr;
  assign pass       = 1'b1;
`endif

  // The last header byte waits until the previous frame's header has been released,
  // so the sideband fields never change under a frame still draining downstream.
  always_comb begin
    s_axis_trdy = 1'b0;
    case (state_q)
      ST_HDR:     s_axis_trdy = en_q & ~(hdr_last & hdr_vld_q);
      ST_PAYLOAD: s_axis_trdy = skid_s_trdy;
      ST_DROP:    s_axis_trdy = en_q;
      default:    s_axis_trdy = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    hdr_d     = hdr_q;
    hdr_vld_d = hdr_vld_q;
    runt_d    = 1'b0;
    drop_d    = 1'b0;
    if (out_done) hdr_vld_d = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (in_fire) begin
          shadow_d = {shadow_q[8*(ETH_HDR_BYTES-2)-1:0], s_axis_tdata};
          if (s_axis_tlast) begin
            runt_d = 1'b1;
            cnt_d  = 4'd0;
          end else if (hdr_last) begin
            cnt_d = 4'd0;
            hdr_d = hdr_next;
            if (pass) begin
              hdr_vld_d = 1'b1;
              state_d   = ST_PAYLOAD;
            end else begin
              state_d = ST_DROP;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_PAYLOAD: if (in_fire && s_axis_tlast) state_d = ST_HDR;
      ST_DROP: begin
        if (in_fire && s_axis_tlast) begin
          drop_d  = 1'b1;
          state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_HDR;
      cnt_q     <= 4'd0;
      shadow_q  <= '0;
      hdr_q     <= '0;
      hdr_vld_q <= 1'b0;
      runt_q    <= 1'b0;
      drop_q    <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      hdr_q     <= hdr_d;
      hdr_vld_q <= hdr_vld_d;
      runt_q    <= runt_d;
      drop_q    <= drop_d;
      en_q      <= 1'b1;
    end
  end

  eth_axis_skid_buf #(
    .DATA_W (AXI_DATA_WIDTH)
  ) u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .s_tdata   (s_axis_tdata),
    .s_tvalid  (skid_s_valid),
    .s_tlast   (s_axis_tlast),
    .s_trdy    (skid_s_trdy),
    .m_tdata   (m_axis_tdata),
    .m_tvalid  (m_axis_tvalid),
    .m_tlast   (m_axis_tlast),
    .m_trdy    (m_axis_trdy)
  );

  assign m_hdr_dest_mac  = hdr_q.dest;
  assign m_hdr_src_mac   = hdr_q.src;
  assign m_hdr_ethertype = hdr_q.ethertype;
  assign m_hdr_valid     = hdr_vld_q;
  assign o_runt_err      = runt_q;
  assign o_frame_drop    = drop_q;

endmodule

// File: tb/tb_ethernet_rx_hdr_parser.sv
// Directed bench for ethernet_rx_hdr_parser: header extraction, runts, filtering,
// header-hold stall, random backpressure and asynchronous reset mid-frame.
module tb_ethernet_rx_hdr_parser;

  logic        i_clk;
  logic        i_reset_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_trdy;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_trdy;
  logic [47:0] m_hdr_dest_mac;
  logic [47:0] m_hdr_src_mac;
  logic [15:0] m_hdr_ethertype;
  logic        m_hdr_valid;
  logic [47:0] i_mac_addr;
  logic        o_runt_err;
  logic        o_frame_drop;

  ethernet_rx_hdr_parser dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_trdy     (s_axis_trdy),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_trdy     (m_axis_trdy),
    .m_hdr_dest_mac  (m_hdr_dest_mac),
    .m_hdr_src_mac   (m_hdr_src_mac),
    .m_hdr_ethertype (m_hdr_ethertype),
    .m_hdr_valid     (m_hdr_valid),
    .i_mac_addr      (i_mac_addr),
    .o_runt_err      (o_runt_err),
    .o_frame_drop    (o_frame_drop)
  );

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] LOCAL = 48'h0200_0000_0001;

  int n_assert = 0;
  int n_fail   = 0;
  int runt_cnt = 0;
  int drop_cnt = 0;
  int hdr_bad  = 0;
  int hold_bad = 0;
  int frm_idx  = 0;
  int ck       = 0;
  int r0, d0, t;

  logic [7:0]  got_d[$];
  logic        got_l[$];
  logic [7:0]  exp_d[$];
  logic        exp_l[$];
  logic [47:0] exp_src[$];
  logic [7:0]  tx_b[$];
  logic        tx_l[$];

  logic       rand_en   = 1'b0;
  logic       trdy_hold = 1'b1;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic       prev_l = 1'b0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk)
    m_axis_trdy = rand_en ? 1'($urandom_range(0, 1)) : trdy_hold;

  // Output-side observer: records beats, pulses, header visibility and hold stability.
  always @(posedge i_clk) begin
    if (!i_reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l))
        hold_bad++;
      if (m_axis_tvalid && m_axis_trdy) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
        if (!m_hdr_valid || frm_idx >= exp_src.size() || m_hdr_src_mac !== exp_src[frm_idx])
          hdr_bad++;
        if (m_axis_tlast) frm_idx++;
      end
      if (o_runt_err)   runt_cnt++;
      if (o_frame_drop) drop_cnt++;
      stall_prev = m_axis_tvalid & ~m_axis_trdy;
      prev_d     = m_axis_tdata;
      prev_l     = m_axis_tlast;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int w;
    @(negedge i_clk);
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = l;
    w = 0;
    while (!s_axis_trdy && w < 2000) begin
      @(negedge i_clk);
      w++;
    end
    if (w >= 2000) begin
      n_assert++;
      n_fail++;
      $error("FAIL tx_accept: s_axis_trdy low for %0d cycles, expected accept", w);
    end
    @(posedge i_clk);
  endtask

  task automatic idle(input int n);
    @(negedge i_clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic build_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                             input int plen, input logic [7:0] seed);
    logic [111:0] h;
    h = {d, s, et};
    tx_b.delete();
    tx_l.delete();
    for (int k = 0; k < 14; k++) begin
      tx_b.push_back(h[111-8*k -: 8]);
      tx_l.push_back(1'b0);
    end
    for (int i = 0; i < plen; i++) begin
      tx_b.push_back(seed + 8'(i));
      tx_l.push_back(i == plen - 1);
    end
  endtask

  task automatic push_exp(input logic [47:0] s, input int plen, input logic [7:0] seed);
    exp_src.push_back(s);
    for (int i = 0; i < plen; i++) begin
      exp_d.push_back(seed + 8'(i));
      exp_l.push_back(i == plen - 1);
    end
  endtask

  task automatic send_range(input int from, input int upto);
    for (int i = from; i < upto; i++) send_byte(tx_b[i], tx_l[i]);
  endtask

  task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                            input int plen, input logic [7:0] seed, input bit fwd);
    build_frame(d, s, et, plen, seed);
    if (fwd) push_exp(s, plen, seed);
    send_range(0, tx_b.size());
  endtask

  task automatic send_raw(input int n, input logic [7:0] seed);
    for (int i = 0; i < n; i++) send_byte(seed + 8'(i), i == n - 1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (got_d.size() != exp_d.size() && w < 5000) begin
      @(negedge i_clk);
      w++;
    end
    repeat (4) @(negedge i_clk);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = ck; i < exp_d.size(); i++) begin
      chk({tag, "_data"}, 64'(got_d[i]), 64'(exp_d[i]));
      chk({tag, "_last"}, 64'(got_l[i]), 64'(exp_l[i]));
    end
    ck = exp_d.size();
  endtask

  initial begin
    i_reset_n     = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    i_mac_addr    = LOCAL;

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst_trdy",   64'(s_axis_trdy), 64'd0);
    chk("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_mdata",  64'(m_axis_tdata), 64'd0);
    chk("rst_hvalid", 64'(m_hdr_valid), 64'd0);
    chk("rst_dest",   64'(m_hdr_dest_mac), 64'd0);
    chk("rst_runt",   64'(o_runt_err), 64'd0);
    chk("rst_drop",   64'(o_frame_drop), 64'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_trdy", 64'(s_axis_trdy), 64'd1);

    // 1: broadcast IPv4 frame, payload 01..06
    send_frame(BCAST, 48'h000A_3501_0203, 16'h0800, 6, 8'h01, 1'b1);
    idle(0);
    chk("t1_hvalid", 64'(m_hdr_valid), 64'd1);
    chk("t1_dest",   64'(m_hdr_dest_mac), 64'(BCAST));
    chk("t1_src",    64'(m_hdr_src_mac), 64'h000A_3501_0203);
    chk("t1_type",   64'(m_hdr_ethertype), 64'h0800);
    drain();
    check_stream("t1");
    chk("t1_hvalid_after", 64'(m_hdr_valid), 64'd0);

    // 2: 10-byte runt then a normal ARP frame
    r0 = runt_cnt;
    send_raw(10, 8'h10);
    idle(4);
    chk("t2_runt_pulse", 64'(runt_cnt - r0), 64'd1);
    chk("t2_hvalid",     64'(m_hdr_valid), 64'd0);
    check_stream("t2_runt");
    send_frame(LOCAL, 48'h0011_2233_4455, 16'h0806, 4, 8'hA0, 1'b1);
    idle(0);
    drain();
    check_stream("t2_next");
    chk("t2_type", 64'(m_hdr_ethertype), 64'h0806);

    // 3: header-only frame is a runt; sideband fields untouched
    r0 = runt_cnt;
    send_raw(14, 8'h20);
    idle(4);
    chk("t3_runt_pulse", 64'(runt_cnt - r0), 64'd1);
    chk("t3_hvalid",     64'(m_hdr_valid), 64'd0);
    chk("t3_type_kept",  64'(m_hdr_ethertype), 64'h0806);
    chk("t3_src_kept",   64'(m_hdr_src_mac), 64'h0011_2233_4455);
    check_stream("t3");

    // 4: destination filtering
    d0 = drop_cnt;
`ifdef ETH_RX_MAC_FILTER_EN
    send_frame(48'h0200_0000_0002, 48'h0A0B_0C0D_0E0F, 16'h0800, 5, 8'h30, 1'b0);
    idle(4);
    chk("t4_drop_pulse", 64'(drop_cnt - d0), 64'd1);
    chk("t4_hvalid",     64'(m_hdr_valid), 64'd0);
`else
    send_frame(48'h0200_0000_0002, 48'h0A0B_0C0D_0E0F, 16'h0800, 5, 8'h30, 1'b1);
    idle(0);
    drain();
    chk("t4_no_drop", 64'(drop_cnt - d0), 64'd0);
`endif
    check_stream("t4_foreign");
    send_frame(LOCAL, 48'h0A0B_0C0D_0E10, 16'h0800, 3, 8'h40, 1'b1);
    idle(0);
    drain();
    check_stream("t4_local");
    chk("t4_dest", 64'(m_hdr_dest_mac), 64'(LOCAL));

    // Header hold: next frame's last header byte stalls until the prior tlast beat leaves
    trdy_hold = 1'b0;
    idle(2);
    send_frame(BCAST, 48'hAAAA_AAAA_AAA1, 16'h0800, 1, 8'h77, 1'b1);
    build_frame(BCAST, 48'hAAAA_AAAA_AAA2, 16'h0806, 3, 8'h90);
    push_exp(48'hAAAA_AAAA_AAA2, 3, 8'h90);
    send_range(0, 13);
    @(negedge i_clk);
    s_axis_tdata  = tx_b[13];
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("hold_trdy",   64'(s_axis_trdy), 64'd0);
    chk("hold_src",    64'(m_hdr_src_mac), 64'hAAAA_AAAA_AAA1);
    chk("hold_hvalid", 64'(m_hdr_valid), 64'd1);
    chk("hold_mvalid", 64'(m_axis_tvalid), 64'd1);
    chk("hold_mdata",  64'(m_axis_tdata), 64'h77);
    chk("hold_mlast",  64'(m_axis_tlast), 64'd1);
    trdy_hold = 1'b1;
    t = 0;
    while (!s_axis_trdy && t < 100) begin
      @(negedge i_clk);
      t++;
    end
    chk("hold_release", 64'(s_axis_trdy), 64'd1);
    @(posedge i_clk);
    send_range(14, tx_b.size());
    idle(0);
    drain();
    check_stream("hold");
    chk("hold_new_type", 64'(m_hdr_ethertype), 64'h0806);

    // 5: back-to-back 64-byte frames under random backpressure
    rand_en = 1'b1;
    send_frame(LOCAL, 48'h0000_0000_00B1, 16'h0800, 50, 8'h00, 1'b1);
    send_frame(LOCAL, 48'h0000_0000_00B2, 16'h0800, 50, 8'h55, 1'b1);
    send_frame(LOCAL, 48'h0000_0000_00B3, 16'h0806, 50, 8'hAA, 1'b1);
    idle(0);
    drain();
    rand_en = 1'b0;
    idle(2);
    check_stream("t5");
    chk("t5_hdr_visibility", 64'(hdr_bad), 64'd0);
    chk("t5_hold_stable",    64'(hold_bad), 64'd0);

    // 6: asynchronous reset with payload stuck in the output stage
    trdy_hold = 1'b0;
    idle(2);
    build_frame(BCAST, 48'h1234_5678_9ABC, 16'h0800, 8, 8'hE0);
    send_range(0, 16);
    @(negedge i_clk);
    #2;
    i_reset_n     = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #1;
    chk("t6_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t6_mdata",  64'(m_axis_tdata), 64'd0);
    chk("t6_hvalid", 64'(m_hdr_valid), 64'd0);
    chk("t6_trdy",   64'(s_axis_trdy), 64'd0);
    chk("t6_src",    64'(m_hdr_src_mac), 64'd0);
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    trdy_hold = 1'b1;
    @(negedge i_clk);
    chk("t6_trdy_after", 64'(s_axis_trdy), 64'd1);
    send_frame(BCAST, 48'h5566_7788_99AA, 16'h0800, 8, 8'hC0, 1'b1);
    idle(0);
    drain();
    check_stream("t6");
    chk("t6_src_new", 64'(m_hdr_src_mac), 64'h5566_7788_99AA);

`ifdef ETH_RX_MAC_FILTER_EN
    chk("total_drops", 64'(drop_cnt), 64'd1);
`else
    chk("total_drops", 64'(drop_cnt), 64'd0);
`endif
    chk("total_runts",      64'(runt_cnt), 64'd2);
    chk("final_hdr_vis",    64'(hdr_bad), 64'd0);
    chk("final_hold",       64'(hold_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
